alu_pipe: RTL and testbench

//  Registered, handshaked, width-parametrised ALU; next generation of the basic_proc combinational ALU.

---
 rtl/alu_pipe.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: registered, valid/ready handshaked ALU with flags.
// Optional feature macro: ALU_MUL_EN enables the iterative shift-add multiply
// (opcode 12). Without it, opcode 12 is treated as a reserved opcode.
`timescale 1ns/1ps
module alu_pipe #(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           InValid,
  output logic           InReady,
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  input  logic [Ops-1:0] OP,
  output logic           OutValid,
  input  logic           OutReady,
  output logic [W-1:0]   Out,
  output logic           Zero,
  output logic           Carry,
  output logic           Neg,
  output logic           Illegal
);

  localparam int SW = $clog2(W);

  localparam logic [Ops-1:0] OP_ADD = Ops'(0);
  localparam logic [Ops-1:0] OP_SUB = Ops'(1);
  localparam logic [Ops-1:0] OP_AND = Ops'(2);
  localparam logic [Ops-1:0] OP_OR  = Ops'(3);
  localparam logic [Ops-1:0] OP_XOR = Ops'(4);
  localparam logic [Ops-1:0] OP_NEG = Ops'(5);
  localparam logic [Ops-1:0] OP_LSH = Ops'(6);
  localparam logic [Ops-1:0] OP_RSH = Ops'(7);
  localparam logic [Ops-1:0] OP_ASR = Ops'(8);
  localparam logic [Ops-1:0] OP_GEQ = Ops'(9);
  localparam logic [Ops-1:0] OP_EQ  = Ops'(10);
  localparam logic [Ops-1:0] OP_NEQ = Ops'(11);

`ifdef ALU_MUL_EN
  localparam logic [Ops-1:0] OP_MUL   = Ops'(12);
  localparam logic [SW-1:0]  CNT_LAST = SW'(W - 1);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

  // Single-cycle result: {illegal, carry, result}. Shifts are done on a
  // (W+1)-bit value so the last bit shifted out falls into the extra bit,
  // which also makes a zero shift amount give carry 0 without a special case.
  function automatic logic [W+1:0] alu_eval(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [Ops-1:0] op);
    logic [W:0]        ext;
    logic signed [W:0] sext;
    logic [SW-1:0]     amt;
    logic [W-1:0]      res;
    logic              c;
    logic              ill;
    amt  = b[SW-1:0];
    ext  = '0;
    sext = '0;
    res  = '0;
    c    = 1'b0;
    ill  = 1'b0;
    case (op)
      OP_ADD: begin ext = {1'b0, a} + {1'b0, b}; res = ext[W-1:0]; c = ext[W]; end
      OP_SUB: begin ext = {1'b0, a} - {1'b0, b}; res = ext[W-1:0]; c = ext[W]; end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NEG: res = {W{1'b0}} - a;
      OP_LSH: begin ext = {1'b0, a} << amt; res = ext[W-1:0]; c = ext[W]; end
      OP_RSH: begin ext = {a, 1'b0} >> amt; res = ext[W:1]; c = ext[0]; end
      OP_ASR: begin sext = $signed({a, 1'b0}) >>> amt; res = sext[W:1]; c = sext[0]; end
      OP_GEQ: res = {{(W-1){1'b0}}, (a >= b)};
      OP_EQ:  res = {{(W-1){1'b0}}, (a == b)};
      OP_NEQ: res = {{(W-1){1'b0}}, (a != b)};
      default: ill = 1'b1;
    endcase
    return {ill, c, res};
  endfunction

  state_t         r_state;
  logic           r_live;
  logic           r_out_valid;
  logic [W-1:0]   r_out;
  logic           r_zero;
  logic           r_carry;
  logic           r_neg;
  logic           r_illegal;

  logic           w_accept;
  logic           w_is_mul;
  logic           w_res_load;
  logic [W+1:0]   w_eval;
  logic [W+1:0]   w_res_val;

`ifdef ALU_MUL_EN
  logic [W-1:0]   r_mul_a;
  logic [W-1:0]   r_mul_b;
  logic [W-1:0]   r_acc;
  logic [SW-1:0]  r_cnt;
  logic [W-1:0]   w_acc_next;
  logic           w_mul_last;

  assign w_is_mul   = (OP == OP_MUL);
  assign w_acc_next = r_acc + (r_mul_b[0] ? r_mul_a : {W{1'b0}});
  assign w_mul_last = (r_state == S_BUSY) && (r_cnt == CNT_LAST);
`else
  assign w_is_mul   = 1'b0;
`endif

  // r_live keeps InReady low until the first edge after reset release.
  assign InReady  = r_live && ((r_state == S_IDLE) || ((r_state == S_DONE) && OutReady));
  assign w_accept = InReady && InValid;
  assign w_eval   = alu_eval(InputA, InputB, OP);

  // Select which result (single-cycle op or finished multiply) loads the output registers.
  always_comb begin
    w_res_load = w_accept && !w_is_mul;
    w_res_val  = w_eval;
`ifdef ALU_MUL_EN
    if (w_mul_last) begin
      w_res_load = 1'b1;
      w_res_val  = {2'b00, w_acc_next};
    end else begin
      w_res_load = w_accept && !w_is_mul;
    end
`endif
  end

  // Handshake state machine and multiply iteration.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      r_live      <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef ALU_MUL_EN
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
`endif
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
`ifdef ALU_MUL_EN
        if (w_is_mul) begin
          r_state     <= S_BUSY;
          r_out_valid <= 1'b0;
          r_mul_a     <= InputA;
          r_mul_b     <= InputB;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
        end
`else
        r_state     <= S_DONE;
        r_out_valid <= 1'b1;
`endif
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_IDLE;
`ifdef ALU_MUL_EN
          S_BUSY: begin
            r_acc   <= w_acc_next;
            r_mul_a <= r_mul_a << 1;
            r_mul_b <= r_mul_b >> 1;
            r_cnt   <= r_cnt + SW'(1);
            if (w_mul_last) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= S_BUSY;
            end
          end
`endif
          S_DONE: begin
            if (OutReady) begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
            end else begin
              r_state     <= S_DONE;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  // Result and flag registers; they change only when a new result is loaded.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_out     <= '0;
      r_zero    <= 1'b1;
      r_carry   <= 1'b0;
      r_neg     <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_res_load) begin
      r_out     <= w_res_val[W-1:0];
      r_zero    <= (w_res_val[W-1:0] == {W{1'b0}});
      r_carry   <= w_res_val[W];
      r_neg     <= w_res_val[W-1];
      r_illegal <= w_res_val[W+1];
    end
  end

  assign OutValid = r_out_valid;
  assign Out      = r_out;
  assign Zero     = r_zero;
  assign Carry    = r_carry;
  assign Neg      = r_neg;
  assign Illegal  = r_illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (W=8): directed steps with a result scoreboard.
`timescale 1ns/1ps
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_d;
  logic       zero;
  logic       carry;
  logic       neg;
  logic       illegal;

  always #5 clk = ~clk;

  alu_pipe #(.W(8), .Ops(4)) dut (
    .Clk(clk), .Reset(rst_n), .InValid(in_valid), .InReady(in_ready),
    .InputA(in_a), .InputB(in_b), .OP(in_op), .OutValid(out_valid),
    .OutReady(out_ready), .Out(out_d), .Zero(zero), .Carry(carry),
    .Neg(neg), .Illegal(illegal)
  );

  typedef struct packed {
    logic [7:0] out;
    logic       zero;
    logic       carry;
    logic       neg;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

`ifdef ALU_MUL_EN
  localparam int MUL_LAT = 9;
`else
  localparam int MUL_LAT = 1;
`endif

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   r;
    int   sa;
    int   amt;
    e   = '0;
    r   = 0;
    amt = int'(b[2:0]);
    sa  = $signed(a);
    case (op)
      4'd0: begin r = int'(a) + int'(b); e.out = r[7:0]; e.carry = (r > 255); end
      4'd1: begin r = int'(a) - int'(b); e.out = r[7:0]; e.carry = (a < b); end
      4'd2: e.out = a & b;
      4'd3: e.out = a | b;
      4'd4: e.out = a ^ b;
      4'd5: begin r = 256 - int'(a); e.out = r[7:0]; end
      4'd6: begin r = int'(a) << amt; e.out = r[7:0]; e.carry = (amt != 0) ? r[8] : 1'b0; end
      4'd7: begin e.out = a >> amt; e.carry = (amt != 0) ? a[amt-1] : 1'b0; end
      4'd8: begin r = sa >>> amt; e.out = r[7:0]; e.carry = (amt != 0) ? a[amt-1] : 1'b0; end
      4'd9:  e.out = (a >= b) ? 8'h01 : 8'h00;
      4'd10: e.out = (a == b) ? 8'h01 : 8'h00;
      4'd11: e.out = (a != b) ? 8'h01 : 8'h00;
`ifdef ALU_MUL_EN
      4'd12: begin r = int'(a) * int'(b); e.out = r[7:0]; end
`endif
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.out == 8'h00);
    e.neg  = e.out[7];
    return e;
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every consumed result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check1("sb_underflow", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check8("sb_out", out_d, e.out);
        check1("sb_zero", zero, e.zero);
        check1("sb_carry", carry, e.carry);
        check1("sb_neg", neg, e.neg);
        check1("sb_illegal", illegal, e.ill);
      end
    end
  end

  // Call at posedge+#1; returns at posedge+#1 after the accepting edge, InValid still high.
  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check1("in_ready_at_accept", in_ready, 1'b1);
    @(posedge clk);
    sb.push_back(model(op, a, b));
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 40);
  endtask

  logic [3:0] t_op [19] = '{4'd0, 4'd1, 4'd8, 4'd6, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd7,
                            4'd7, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
  logic [7:0] t_a  [19] = '{8'hFF, 8'h03, 8'h80, 8'h81, 8'hF0, 8'hF0, 8'h5A, 8'h01, 8'h00, 8'h81,
                            8'h81, 8'hC3, 8'h7F, 8'h03, 8'h07, 8'h07, 8'h12, 8'h34, 8'h56};
  logic [7:0] t_b  [19] = '{8'h01, 8'h05, 8'h03, 8'h01, 8'h3C, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h01,
                            8'h0F, 8'h08, 8'h02, 8'h04, 8'h07, 8'h07, 8'h01, 8'h02, 8'h03};

  initial begin
    int  n;
    logic seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_op     = 4'd0;

    // Reset values.
    repeat (2) @(negedge clk);
    check1("rst_out_valid", out_valid, 1'b0);
    check8("rst_out", out_d, 8'h00);
    check1("rst_zero", zero, 1'b1);
    check1("rst_carry", carry, 1'b0);
    check1("rst_neg", neg, 1'b0);
    check1("rst_illegal", illegal, 1'b0);
    check1("rst_in_ready", in_ready, 1'b0);

    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check1("in_ready_before_edge", in_ready, 1'b0);
    @(negedge clk);
    check1("in_ready_after_edge", in_ready, 1'b1);

    // Directed single-cycle operations, one at a time.
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 19; i++) begin
      drive(t_op[i], t_a[i], t_b[i]);
      in_valid = 1'b0;
      wait_valid(n);
      check8("latency_single", 8'(n), 8'd1);
      @(posedge clk); #1;
    end

    // Back-to-back OR then GEQ with no bubble.
    drive(4'd3, 8'h0F, 8'h30);
    drive(4'd9, 8'h10, 8'h10);
    in_valid = 1'b0;
    @(negedge clk);
    check1("b2b_second_valid", out_valid, 1'b1);
    @(posedge clk); #1;

    // Backpressure: EQ 5,6 held while a new request waits.
    out_ready = 1'b0;
    drive(4'd10, 8'h05, 8'h06);
    in_op = 4'd0; in_a = 8'h01; in_b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("bp_valid", out_valid, 1'b1);
      check8("bp_out", out_d, 8'h00);
      check1("bp_zero", zero, 1'b1);
      check1("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check1("bp_release_ready", in_ready, 1'b1);
    @(posedge clk);
    sb.push_back(model(4'd0, 8'h01, 8'h01));
    #1 in_valid = 1'b0;
    wait_valid(n);
    check8("bp_next_latency", 8'(n), 8'd1);
    @(posedge clk); #1;

    // Multiply latency and result.
    drive(4'd12, 8'h0D, 8'h0B);
    in_valid = 1'b0;
    wait_valid(n);
    check8("mul_latency", 8'(n), 8'(MUL_LAT));
    @(posedge clk); #1;

    // Reset while a multiply is in flight (or its result is pending).
    out_ready = 1'b0;
    drive(4'd12, 8'h0D, 8'h0B);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check1("midrst_out_valid", out_valid, 1'b0);
    check8("midrst_out", out_d, 8'h00);
    check1("midrst_zero", zero, 1'b1);
    check1("midrst_in_ready", in_ready, 1'b0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check1("no_valid_after_reset", seen, 1'b0);

    // ADD after reset: wrap to zero with carry.
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(4'd0, 8'hFF, 8'h01);
    in_valid = 1'b0;
    wait_valid(n);
    check8("post_rst_latency", 8'(n), 8'd1);
    check8("post_rst_out", out_d, 8'h00);
    check1("post_rst_carry", carry, 1'b1);
    @(posedge clk); #1;
    repeat (2) @(negedge clk);

    check8("sb_drained", 8'(sb.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
